// File: rtl/bl_mask_pkg.sv
// Shared constants for the bitline write-mask generator: width-configuration
// encodings, default geometry and lane/half mask patterns.
package bl_mask_pkg;

  localparam logic [1:0] CONF_W32  = 2'b00;
  localparam logic [1:0] CONF_W16  = 2'b01;
  localparam logic [1:0] CONF_W8   = 2'b10;
  localparam logic [1:0] CONF_RSVD = 2'b11;

  localparam int DATA_W_DEF = 32;
  localparam int MIN_W_DEF  = 8;

  localparam logic [7:0]  LANE_MASK = 8'hFF;
  localparam logic [15:0] HALF_MASK = 16'hFFFF;

endpackage

// File: rtl/bl_mask_decode.sv
// Combinational (conf, addr) -> bitline mask. A 4-bit lane-enable vector is
// computed first, then each lane bit is replicated across its MIN_W bitlines.
module bl_mask_decode
  import bl_mask_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MIN_W  = MIN_W_DEF
) (
  input  logic [1:0]        conf,
  input  logic [1:0]        addr,
  output logic [DATA_W-1:0] mask
);

  localparam int LANES = DATA_W / MIN_W;

  logic [LANES-1:0] lane_en;

  always_comb begin
    lane_en = '0;
    case (conf)
      CONF_W32: lane_en = '1;
      CONF_W16: lane_en = addr[0] ? 4'b1100 : 4'b0011;
      CONF_W8:  lane_en = 4'b0001 << addr;
      default:  lane_en = '0; // reserved: drive no bitlines
    endcase
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    assign mask[l*MIN_W +: MIN_W] = {MIN_W{lane_en[l]}};
  end

endmodule

// File: rtl/bl_mask_8_32.sv
// Bitline write-mask generator for the 32-bit SRAM column array; the decoded
// mask is registered with a synchronous active-low reset.
module bl_mask_8_32
  import bl_mask_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int MIN_W  = MIN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        conf,
  input  logic [1:0]        addr,
  output logic [DATA_W-1:0] bl_mask
);

  logic [DATA_W-1:0] mask_d;
  logic [DATA_W-1:0] mask_q;

  bl_mask_decode #(
    .DATA_W (DATA_W),
    .MIN_W  (MIN_W)
  ) u_decode (
    .conf (conf),
    .addr (addr),
    .mask (mask_d)
  );

  // Reset wins over decode on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) mask_q <= '0;
    else        mask_q <= mask_d;
  end

  assign bl_mask = mask_q;

endmodule

// File: tb/tb_bl_mask_8_32.sv
// Directed bench for bl_mask_8_32: reset, each width mode, reserved mode,
// mid-stream reset and back-to-back sweep of all conf/addr combinations.
module tb_bl_mask_8_32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  conf;
  logic [1:0]  addr;
  logic [31:0] bl_mask;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bl_mask_8_32 dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .conf    (conf),
    .addr    (addr),
    .bl_mask (bl_mask)
  );

  // Hand-written reference table of the decode.
  function automatic logic [31:0] ref_mask(input logic [1:0] c, input logic [1:0] a);
    case (c)
      2'b00: ref_mask = 32'hFFFF_FFFF;
      2'b01: ref_mask = a[0] ? 32'hFFFF_0000 : 32'h0000_FFFF;
      2'b10: begin
        case (a)
          2'b00:   ref_mask = 32'h0000_00FF;
          2'b01:   ref_mask = 32'h0000_FF00;
          2'b10:   ref_mask = 32'h00FF_0000;
          default: ref_mask = 32'hFF00_0000;
        endcase
      end
      default: ref_mask = 32'h0000_0000;
    endcase
  endfunction

  // Present inputs, then sample one edge later, 1 ns after the edge.
  task automatic drive_cycle(input logic [1:0] c, input logic [1:0] a);
    conf = c;
    addr = a;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    conf  = 2'b00;
    addr  = 2'b00;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if (bl_mask !== 32'h0000_0000) begin
        errors++;
        $display("FAIL reset_hold cycle %0d: got %h expected %h", i, bl_mask, 32'h0);
      end
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bl_mask !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL reset_release: got %h expected %h", bl_mask, 32'hFFFF_FFFF);
    end
  endtask

  task automatic test_mode(input logic [1:0] c, input logic [31:0] e0,
                           input logic [31:0] e1, input logic [31:0] e2,
                           input logic [31:0] e3);
    logic [31:0] exp_tab [4];
    exp_tab[0] = e0;
    exp_tab[1] = e1;
    exp_tab[2] = e2;
    exp_tab[3] = e3;
    for (int a = 0; a < 4; a++) begin
      drive_cycle(c, 2'(a));
      checks++;
      if (bl_mask !== exp_tab[a]) begin
        errors++;
        $display("FAIL mode conf=%b addr=%0d: got %h expected %h", c, a, bl_mask, exp_tab[a]);
      end
    end
  endtask

  task automatic test_reserved_and_midreset();
    drive_cycle(2'b10, 2'b11);
    checks++;
    if (bl_mask !== 32'hFF00_0000) begin
      errors++;
      $display("FAIL pre_reset_value: got %h expected %h", bl_mask, 32'hFF00_0000);
    end
    rst_n = 1'b0;
    drive_cycle(2'b10, 2'b11);
    checks++;
    if (bl_mask !== 32'h0000_0000) begin
      errors++;
      $display("FAIL midstream_reset: got %h expected %h", bl_mask, 32'h0);
    end
    rst_n = 1'b1;
    drive_cycle(2'b10, 2'b11);
    checks++;
    if (bl_mask !== 32'hFF00_0000) begin
      errors++;
      $display("FAIL post_reset_first: got %h expected %h", bl_mask, 32'hFF00_0000);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] exp_v;
    int          exp_pop;
    for (int i = 0; i < 16; i++) begin
      logic [1:0] c;
      logic [1:0] a;
      c = 2'(i >> 2);
      a = 2'(i);
      exp_q.push_back(ref_mask(c, a));
      drive_cycle(c, a);
      exp_v = exp_q.pop_front();
      checks++;
      if (bl_mask !== exp_v) begin
        errors++;
        $display("FAIL b2b conf=%b addr=%b: got %h expected %h", c, a, bl_mask, exp_v);
      end
      case (c)
        2'b00:   exp_pop = 32;
        2'b01:   exp_pop = 16;
        2'b10:   exp_pop = 8;
        default: exp_pop = 0;
      endcase
      checks++;
      if ($countones(bl_mask) !== exp_pop) begin
        errors++;
        $display("FAIL popcount conf=%b addr=%b: got %0d expected %0d",
                 c, a, $countones(bl_mask), exp_pop);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    test_mode(2'b01, 32'h0000_FFFF, 32'hFFFF_0000, 32'h0000_FFFF, 32'hFFFF_0000);
    test_mode(2'b10, 32'h0000_00FF, 32'h0000_FF00, 32'h00FF_0000, 32'hFF00_0000);
    test_mode(2'b11, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000);
    test_reserved_and_midreset();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
